// File: rtl/sysahb_sys_timer.sv
// sysahb_sys_timer: AHB-lite system timer. It has a CNT_W-bit up-counter with a
// programmable prescaler and run/stop control, and NUM_CMP compare channels.
// Each compare channel raises a level interrupt when the count reaches its
// compare value. OKAY transfers complete with zero wait states. Unmapped or
// non-word accesses get a two-cycle ERROR response.
module sysahb_sys_timer #(
  parameter int CNT_W   = 64,
  parameter int NUM_CMP = 4,
  parameter int PRESC_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_resetn,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [31:0]        hwdata,
  output logic [31:0]        hrdata,
  output logic               hready,
  output logic               hresp,
  output logic [CNT_W-1:0]   sys_cnt,
  output logic [NUM_CMP-1:0] timer_int_vld
);

  localparam int HI_W = CNT_W - 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t               state_q, state_d;
  logic                 addr_acc, addr_err;
  logic                 dp_act_q, dp_wr_q;
  logic [7:0]           dp_addr_q;
  logic                 wr_en;
  logic                 en_q;
  logic [PRESC_W-1:0]   presc_q, pc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_CMP-1:0]   stat_q, int_en_q, int_vld_q, hit, w1c;
  logic [CNT_W-1:0]     cmp_q [NUM_CMP];
  logic [31:0]          rd_data;
  logic                 unused_bits;

  function automatic logic [7:0] cmp_lo_off(input int i);
    return 8'(32 + 8 * i);
  endfunction

  function automatic logic [7:0] cmp_hi_off(input int i);
    return 8'(36 + 8 * i);
  endfunction

  function automatic logic addr_mapped(input logic [7:0] a);
    logic ok;
    ok = (a == 8'h00) || (a == 8'h04) || (a == 8'h08) ||
         (a == 8'h0C) || (a == 8'h10);
    for (int i = 0; i < NUM_CMP; i++) begin
      if (a == cmp_lo_off(i) || a == cmp_hi_off(i)) ok = 1'b1;
    end
    return ok;
  endfunction

  // Only haddr[7:0] is decoded, and htrans[0] does not matter (NONSEQ and SEQ are treated alike).
  assign unused_bits = ^{haddr[31:8], htrans[0]};

  assign addr_acc = hsel & htrans[1] & hready;
  assign addr_err = !addr_mapped(haddr[7:0]) || (hsize != 3'b010);
  assign wr_en    = dp_act_q & dp_wr_q;

  // ERROR response: cycle 1 stalls (hready low), cycle 2 completes.
  assign hready = (state_q != ST_ERR1);
  assign hresp  = (state_q != ST_IDLE);

  // Bus response state register
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Bus response next state; a new erroring address phase may follow ERR2 back-to-back
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = (addr_acc && addr_err) ? ST_ERR1 : ST_IDLE;
    endcase
  end

  // Address phase capture; only OKAY transfers open a data phase
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      dp_act_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
    end else begin
      dp_act_q <= addr_acc & ~addr_err;
      if (addr_acc) begin
        dp_wr_q   <= hwrite;
        dp_addr_q <= haddr[7:0];
      end
    end
  end

  // Prescaler and counter; bus writes to either counter half override the increment
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      en_q    <= 1'b0;
      presc_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (en_q) begin
        if (pc_q == presc_q) begin
          pc_q  <= '0;
          cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          pc_q  <= pc_q + PRESC_W'(1);
        end
      end
      if (wr_en && dp_addr_q == 8'h00) begin
        en_q    <= hwdata[0];
        presc_q <= hwdata[PRESC_W+7:8];
        pc_q    <= '0;
      end
      if (wr_en && dp_addr_q == 8'h04) cnt_q <= {cnt_q[CNT_W-1:32], hwdata};
      if (wr_en && dp_addr_q == 8'h08) cnt_q <= {hwdata[HI_W-1:0], cnt_q[31:0]};
    end
  end

  // Compare values and interrupt enables
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      int_en_q <= '0;
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '0;
    end else if (wr_en) begin
      if (dp_addr_q == 8'h10) int_en_q <= hwdata[NUM_CMP-1:0];
      for (int i = 0; i < NUM_CMP; i++) begin
        if (dp_addr_q == cmp_lo_off(i)) cmp_q[i] <= {cmp_q[i][CNT_W-1:32], hwdata};
        if (dp_addr_q == cmp_hi_off(i)) cmp_q[i] <= {hwdata[HI_W-1:0], cmp_q[i][31:0]};
      end
    end
  end

  // Compare hits and write-1-to-clear mask
  always_comb begin
    hit = '0;
    w1c = '0;
    for (int i = 0; i < NUM_CMP; i++) hit[i] = (cnt_q >= cmp_q[i]);
    if (wr_en && dp_addr_q == 8'h0C) w1c = hwdata[NUM_CMP-1:0];
  end

  // Sticky status; a hit in the clearing cycle keeps the bit set. The interrupt is STAT & INT_EN, one register later.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      stat_q    <= '0;
      int_vld_q <= '0;
    end else begin
      stat_q    <= hit | (stat_q & ~w1c);
      int_vld_q <= stat_q & int_en_q;
    end
  end

  // Read mux for the data phase; unimplemented bits read as zero
  always_comb begin
    rd_data = '0;
    case (dp_addr_q)
      8'h00: begin
        rd_data[0]           = en_q;
        rd_data[PRESC_W+7:8] = presc_q;
      end
      8'h04: rd_data = cnt_q[31:0];
      8'h08: rd_data[HI_W-1:0] = cnt_q[CNT_W-1:32];
      8'h0C: rd_data[NUM_CMP-1:0] = stat_q;
      8'h10: rd_data[NUM_CMP-1:0] = int_en_q;
      default: begin
        for (int i = 0; i < NUM_CMP; i++) begin
          if (dp_addr_q == cmp_lo_off(i)) rd_data = cmp_q[i][31:0];
          if (dp_addr_q == cmp_hi_off(i)) rd_data[HI_W-1:0] = cmp_q[i][CNT_W-1:32];
        end
      end
    endcase
  end

  assign hrdata        = (dp_act_q && !dp_wr_q) ? rd_data : 32'h0;
  assign sys_cnt       = cnt_q;
  assign timer_int_vld = int_vld_q;

endmodule

// File: tb/tb_sysahb_sys_timer.sv
// Directed testbench for sysahb_sys_timer with its default parameters.
module tb_sysahb_sys_timer;

  localparam int CNT_W   = 64;
  localparam int NUM_CMP = 4;
  localparam int PRESC_W = 8;

  logic               sys_clk = 1'b0;
  logic               sys_resetn = 1'b0;
  logic               hsel = 1'b0;
  logic [31:0]        haddr = '0;
  logic [1:0]         htrans = 2'b00;
  logic               hwrite = 1'b0;
  logic [2:0]         hsize = 3'b010;
  logic [31:0]        hwdata = '0;
  logic [31:0]        hrdata;
  logic               hready, hresp;
  logic [CNT_W-1:0]   sys_cnt;
  logic [NUM_CMP-1:0] timer_int_vld;

  int n_chk  = 0;
  int n_fail = 0;

  sysahb_sys_timer #(.CNT_W(CNT_W), .NUM_CMP(NUM_CMP), .PRESC_W(PRESC_W)) dut (
    .sys_clk       (sys_clk),
    .sys_resetn    (sys_resetn),
    .hsel          (hsel),
    .haddr         (haddr),
    .htrans        (htrans),
    .hwrite        (hwrite),
    .hsize         (hsize),
    .hwdata        (hwdata),
    .hrdata        (hrdata),
    .hready        (hready),
    .hresp         (hresp),
    .sys_cnt       (sys_cnt),
    .timer_int_vld (timer_int_vld)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
    haddr  = '0;
  endtask

  task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = {24'h0, a};
    @(posedge sys_clk); #1;
    idle_bus();
    hwdata = d;
    @(posedge sys_clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = {24'h0, a};
    @(posedge sys_clk); #1;
    idle_bus();
    chk(tag, {32'h0, hrdata}, {32'h0, exp});
  endtask

  task automatic err_access(input string tag, input logic [7:0] a, input logic wr,
                            input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = {24'h0, a};
    @(posedge sys_clk); #1;
    idle_bus();
    hwdata = 32'h0;
    chk({tag, "_c1_hready"}, 64'(hready), 64'd0);
    chk({tag, "_c1_hresp"},  64'(hresp),  64'd1);
    chk({tag, "_c1_hrdata"}, 64'(hrdata), 64'd0);
    @(posedge sys_clk); #1;
    chk({tag, "_c2_hready"}, 64'(hready), 64'd1);
    chk({tag, "_c2_hresp"},  64'(hresp),  64'd1);
    @(posedge sys_clk); #1;
    chk({tag, "_done_hresp"}, 64'(hresp), 64'd0);
  endtask

  initial begin
    logic found;

    // T1: reset values, then every register reads back its reset content
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_hready", 64'(hready), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    chk("rst_cnt", sys_cnt, 64'd0);
    chk("rst_int", 64'(timer_int_vld), 64'd0);
    sys_resetn = 1'b1;
    @(posedge sys_clk); #1;
    rd_chk("t1_ctrl", 8'h00, 32'h0);
    rd_chk("t1_cnt_lo", 8'h04, 32'h0);
    rd_chk("t1_cnt_hi", 8'h08, 32'h0);
    // Every CMP register resets to 0, so cnt >= CMP already holds when the
    // counter leaves reset. All STAT bits are set one cycle after reset.
    rd_chk("t1_stat", 8'h0C, 32'hF);
    rd_chk("t1_int_en", 8'h10, 32'h0);
    for (int i = 0; i < 2 * NUM_CMP; i++) begin
      rd_chk($sformatf("t1_cmp_%0d", i), 8'(32 + 4 * i), 32'h0);
    end
    chk("t1_int", 64'(timer_int_vld), 64'd0);
    chk("t1_hresp", 64'(hresp), 64'd0);

    // T2: PRESC=3 gives one increment every four cycles; EN=0 freezes the count
    ahb_wr(8'h00, 32'h0000_0301);
    chk("t2_cnt_start", sys_cnt, 64'd0);
    repeat (4) @(posedge sys_clk);
    #1 chk("t2_cnt_4", sys_cnt, 64'd1);
    repeat (3) @(posedge sys_clk);
    #1 chk("t2_cnt_7", sys_cnt, 64'd1);
    @(posedge sys_clk);
    #1 chk("t2_cnt_8", sys_cnt, 64'd2);
    ahb_wr(8'h00, 32'h0);
    repeat (10) @(posedge sys_clk);
    #1 chk("t2_cnt_hold", sys_cnt, 64'd2);
    rd_chk("t2_ctrl", 8'h00, 32'h0);
    rd_chk("t2_cnt_lo", 8'h04, 32'h2);

    // T3: wrap from all-ones to zero with PRESC=0
    ahb_wr(8'h04, 32'hFFFF_FFFF);
    ahb_wr(8'h08, 32'hFFFF_FFFF);
    chk("t3_cnt_ones", sys_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    ahb_wr(8'h00, 32'h0000_0001);
    chk("t3_cnt_ones_run", sys_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge sys_clk);
    #1 chk("t3_cnt_wrap", sys_cnt, 64'd0);
    chk("t3_int", 64'(timer_int_vld), 64'd0);
    rd_chk("t3_cnt_hi", 8'h08, 32'h0);

    // T4: compare channel 0 at 10, W1C behaviour while the hit holds and after it drops
    ahb_wr(8'h00, 32'h0);
    ahb_wr(8'h04, 32'h0);
    ahb_wr(8'h08, 32'h0);
    ahb_wr(8'h20, 32'd10);
    ahb_wr(8'h0C, 32'hF);
    rd_chk("t4_stat_clr", 8'h0C, 32'hE);
    ahb_wr(8'h10, 32'h1);
    chk("t4_int_idle", 64'(timer_int_vld), 64'd0);
    ahb_wr(8'h00, 32'h0000_0001);
    chk("t4_cnt_start", sys_cnt, 64'd0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (sys_cnt == 64'd10) found = 1'b1;
      else begin
        @(posedge sys_clk); #1;
      end
    end
    chk("t4_reach10", 64'(found), 64'd1);
    chk("t4_int_at10", 64'(timer_int_vld), 64'd0);
    repeat (2) @(posedge sys_clk);
    #1 chk("t4_int_set", 64'(timer_int_vld), 64'd1);
    chk("t4_cnt_12", sys_cnt, 64'd12);
    ahb_wr(8'h0C, 32'h1);
    rd_chk("t4_stat_setwins", 8'h0C, 32'hF);
    chk("t4_int_held", 64'(timer_int_vld), 64'd1);
    ahb_wr(8'h20, 32'hFFFF_FFFF);
    ahb_wr(8'h24, 32'h0000_FFFF);
    rd_chk("t4_cmp0_hi", 8'h24, 32'h0000_FFFF);
    ahb_wr(8'h0C, 32'h1);
    rd_chk("t4_stat_cleared", 8'h0C, 32'hE);
    chk("t4_int_drop", 64'(timer_int_vld), 64'd0);

    // Back-to-back: write CMP1_LO, then read it in the very next address phase
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h28;
    @(posedge sys_clk); #1;
    hwdata = 32'h1234_5678;
    hwrite = 1'b0;
    @(posedge sys_clk); #1;
    idle_bus();
    chk("b2b_rd", 64'(hrdata), 64'h1234_5678);
    chk("b2b_hready", 64'(hready), 64'd1);

    // T5: unmapped read and byte write each get the two-cycle ERROR response and change nothing
    err_access("t5_unmapped", 8'h14, 1'b0, 3'b010);
    err_access("t5_byte_wr", 8'h00, 1'b1, 3'b000);
    rd_chk("t5_ctrl_kept", 8'h00, 32'h1);
    // An address phase offered while hready is low must be dropped
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h14;
    @(posedge sys_clk); #1;
    haddr = 32'h10; hwrite = 1'b1;
    chk("t5_stall_hready", 64'(hready), 64'd0);
    @(posedge sys_clk); #1;
    idle_bus();
    hwdata = 32'h0;
    @(posedge sys_clk); #1;
    chk("t5_stall_hresp", 64'(hresp), 64'd0);
    rd_chk("t5_int_en_kept", 8'h10, 32'h1);

    // T6: asynchronous reset during ERROR cycle 1
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h14;
    @(posedge sys_clk); #1;
    idle_bus();
    chk("t6_pre_hready", 64'(hready), 64'd0);
    #2 sys_resetn = 1'b0;
    #1;
    chk("t6_hready", 64'(hready), 64'd1);
    chk("t6_hresp", 64'(hresp), 64'd0);
    chk("t6_cnt", sys_cnt, 64'd0);
    chk("t6_hrdata", 64'(hrdata), 64'd0);
    chk("t6_int", 64'(timer_int_vld), 64'd0);
    @(posedge sys_clk); #1;
    sys_resetn = 1'b1;
    @(posedge sys_clk); #1;
    rd_chk("t6_ctrl_after", 8'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
